// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions used by both pointer blocks.
// Gray helpers work on a 32-bit zero-extended value; callers truncate.
package fifo_pkg;

    localparam int FIFO_ADDRSIZE = 4;
    localparam int GRAY_W = 32;

    typedef logic [GRAY_W-1:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t b);
        return (b >> 1) ^ b;
    endfunction

    // Leading zeros of a zero-extended code stay zero, so truncation is exact.
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b = g;
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full.sv
// Write-side pointer, full/almost-full, level and overflow logic
// for the asynchronous FIFO; every output comes straight from a flop.
module wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE     = FIFO_ADDRSIZE,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                wclr_ovf,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] DEPTH  = PW'(1) << ADDRSIZE;
    localparam logic [PW-1:0] THRESH = DEPTH - PW'(AFULL_MARGIN);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbinnext;
    logic [PW-1:0] wgraynext;
    logic [PW-1:0] rbin;
    logic [PW-1:0] full_cmp;
    logic [PW-1:0] level_next;
    logic          push;
    logic          wfull_next;
    logic          afull_next;
    logic          ovf_attempt;

    assign push        = winc && !wfull;
    assign ovf_attempt = winc && wfull;

    assign wbinnext  = wbin + PW'(push);
    assign wgraynext = PW'(bin2gray(GRAY_W'(wbinnext)));
    assign rbin      = PW'(gray2bin(GRAY_W'(wq2_rptr)));

    // Full when the write pointer has lapped the read pointer once.
    assign full_cmp   = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                         wq2_rptr[ADDRSIZE-2:0]};
    assign wfull_next = (wgraynext == full_cmp);

    assign level_next = wbinnext - rbin;
    assign afull_next = (level_next >= THRESH);

    assign waddr = wbin[ADDRSIZE-1:0];

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= wfull_next;
            walmost_full <= afull_next;
            wlevel       <= level_next;
            if (ovf_attempt) begin
                woverflow <= 1'b1;
            end else if (wclr_ovf) begin
                woverflow <= 1'b0;
            end
        end
    end

endmodule
